// File: rtl/udp_rx_parser.sv
// udp_rx_parser
// MII (4-bit nibble) UDP/IPv4 receive parser. Strips preamble, Ethernet, IPv4 and UDP
// headers, filters on destination MAC, destination IP, fragmentation and UDP destination
// port over NCH consecutive port channels, and streams payload bytes with SOF/EOF/channel
// tags. Keeps saturating counts of delivered and rejected frames.
//
// Optional feature: define UDP_RX_IPCSUM_EN to verify the IPv4 header checksum. A frame
// whose header does not sum to 16'hFFFF is dropped before any payload strobe. When the
// macro is undefined, the checksum field is ignored and no adder is built.
//
// Ports
//   r_clk     in   receive clock (MII RX clock)
//   rst       in   synchronous, active-high reset
//   r_dv      in   MII receive data valid
//   datain    in   MII receive nibble, low nibble of each byte first
//   rx_data   out  payload byte
//   rx_valid  out  rx_data strobe, one cycle per byte
//   rx_sof    out  with rx_valid: first payload byte
//   rx_eof    out  with rx_valid: last payload byte
//   rx_ch     out  channel index (dst port - PORT_BASE), stable from SOF to EOF
//   rx_abort  out  one-cycle pulse when r_dv drops before the last payload byte
//   src_mac   out  source MAC of the current/last frame that reached payload
//   src_ip    out  source IPv4 address of the current/last frame that reached payload
//   src_port  out  UDP source port of the current/last frame that reached payload
//   pkt_cnt   out  frames delivered, saturating
//   drop_cnt  out  frames rejected after SFD, saturating
module udp_rx_parser #(
  parameter logic [47:0] LOCAL_MAC    = 48'h00_0A_35_01_FE_C0,
  parameter logic [31:0] LOCAL_IP     = 32'hC0_A8_00_02,
  parameter logic [15:0] PORT_BASE    = 16'd8080,
  parameter int unsigned NCH          = 4,
  parameter bit          ACCEPT_BCAST = 1'b1,
  localparam int unsigned CHW         = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           r_clk,
  input  logic           rst,
  input  logic           r_dv,
  input  logic [3:0]     datain,
  output logic [7:0]     rx_data,
  output logic           rx_valid,
  output logic           rx_sof,
  output logic           rx_eof,
  output logic [CHW-1:0] rx_ch,
  output logic           rx_abort,
  output logic [47:0]    src_mac,
  output logic [31:0]    src_ip,
  output logic [15:0]    src_port,
  output logic [15:0]    pkt_cnt,
  output logic [15:0]    drop_cnt
);

  typedef enum logic [2:0] {
    StIdle, StPre, StEth, StIp, StUdp, StData, StWait, StDrop
  } state_e;

  state_e         state_q;
  logic           phase_q;   // 0: expecting low nibble, 1: expecting high nibble
  logic [3:0]     lo_q;      // held low nibble (also previous nibble while in StPre)
  logic [7:0]     prev_q;    // previous header byte, for 16-bit fields
  logic [39:0]    sh_q;      // last five header bytes, for 32/48-bit fields
  logic [5:0]     idx_q;     // header byte index after SFD (0..41)
  logic [47:0]    smac_q;
  logic [31:0]    sip_q;
  logic [15:0]    sport_q;
  logic [CHW-1:0] ch_q;
  logic [15:0]    remain_q;  // payload bytes still to deliver
  logic           first_q;

  logic [7:0]  byte_w;
  logic [15:0] word_w;
  logic [47:0] dmac_w;
  logic [31:0] dip_w;
  logic        mac_ok;
  logic        port_ok;
  logic        csum_bad;
  logic        hdr_fail;

  assign byte_w = {datain, lo_q};
  assign word_w = {prev_q, byte_w};
  assign dmac_w = {sh_q, byte_w};
  assign dip_w  = {sh_q[23:0], byte_w};
  assign mac_ok = (dmac_w == LOCAL_MAC) ||
                  (ACCEPT_BCAST && (dmac_w == 48'hFFFF_FFFF_FFFF));
  assign port_ok = ({1'b0, word_w} >= {1'b0, PORT_BASE}) &&
                   ({1'b0, word_w} < ({1'b0, PORT_BASE} + 17'(NCH)));

`ifdef UDP_RX_IPCSUM_EN
  logic [15:0] csum_q;
  logic [16:0] csum_sum;
  logic [15:0] csum_next;

  // Ones-complement accumulate with end-around carry; the folded sum cannot carry again.
  assign csum_sum  = {1'b0, csum_q} + {1'b0, word_w};
  assign csum_next = csum_sum[15:0] + {15'd0, csum_sum[16]};
  assign csum_bad  = (csum_next != 16'hFFFF);

  // Header words complete on odd byte indices 15..33 while in StIp.
  always_ff @(posedge r_clk) begin
    if (rst || (state_q == StPre)) begin
      csum_q <= '0;
    end else if ((state_q == StIp) && r_dv && phase_q && idx_q[0]) begin
      csum_q <= csum_next;
    end
  end
`else
  assign csum_bad = 1'b0;
`endif

  // Each filter check fires on the byte that completes its field.
  always_comb begin
    hdr_fail = 1'b0;
    case (idx_q)
      6'd5:    hdr_fail = !mac_ok;
      6'd13:   hdr_fail = (word_w != 16'h0800);
      6'd14:   hdr_fail = (byte_w != 8'h45);
      6'd21:   hdr_fail = prev_q[5] || (prev_q[4:0] != 5'd0) || (byte_w != 8'd0);
      6'd23:   hdr_fail = (byte_w != 8'h11);
      6'd33:   hdr_fail = (dip_w != LOCAL_IP) || csum_bad;
      6'd37:   hdr_fail = !port_ok;
      6'd39:   hdr_fail = (word_w < 16'd8);
      default: hdr_fail = 1'b0;
    endcase
  end

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge r_clk) begin
    if (rst) begin
      state_q  <= StIdle;
      phase_q  <= 1'b0;
      lo_q     <= '0;
      prev_q   <= '0;
      sh_q     <= '0;
      idx_q    <= '0;
      smac_q   <= '0;
      sip_q    <= '0;
      sport_q  <= '0;
      ch_q     <= '0;
      remain_q <= '0;
      first_q  <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_sof   <= 1'b0;
      rx_eof   <= 1'b0;
      rx_ch    <= '0;
      rx_abort <= 1'b0;
      src_mac  <= '0;
      src_ip   <= '0;
      src_port <= '0;
      pkt_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      rx_valid <= 1'b0;
      rx_sof   <= 1'b0;
      rx_eof   <= 1'b0;
      rx_abort <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (r_dv) begin
            state_q <= StPre;
            phase_q <= 1'b0;
            lo_q    <= datain;
          end
        end

        // SFD is matched nibble-wise (5 then D) so the byte alignment of the preamble
        // does not matter; byte phase restarts right after it.
        StPre: begin
          if (!r_dv) begin
            state_q <= StIdle;
          end else begin
            lo_q <= datain;
            if ((lo_q == 4'h5) && (datain == 4'hD)) begin
              state_q <= StEth;
              phase_q <= 1'b0;
              idx_q   <= '0;
            end
          end
        end

        StEth, StIp, StUdp: begin
          if (!r_dv) begin
            state_q  <= StIdle;
            drop_cnt <= sat_inc(drop_cnt);
          end else if (!phase_q) begin
            lo_q    <= datain;
            phase_q <= 1'b1;
          end else begin
            phase_q <= 1'b0;
            prev_q  <= byte_w;
            sh_q    <= {sh_q[31:0], byte_w};
            idx_q   <= idx_q + 6'd1;
            if (hdr_fail) begin
              state_q  <= StDrop;
              drop_cnt <= sat_inc(drop_cnt);
            end else begin
              case (idx_q)
                6'd11: smac_q   <= dmac_w;
                6'd13: state_q  <= StIp;
                6'd29: sip_q    <= dip_w;
                6'd33: state_q  <= StUdp;
                6'd35: sport_q  <= word_w;
                6'd37: ch_q     <= CHW'(word_w - PORT_BASE);
                6'd39: remain_q <= word_w - 16'd8;
                6'd41: begin
                  if (remain_q == 16'd0) begin
                    state_q <= StWait;
                    pkt_cnt <= sat_inc(pkt_cnt);
                  end else begin
                    state_q  <= StData;
                    first_q  <= 1'b1;
                    rx_ch    <= ch_q;
                    src_mac  <= smac_q;
                    src_ip   <= sip_q;
                    src_port <= sport_q;
                  end
                end
                default: ;
              endcase
            end
          end
        end

        StData: begin
          if (!r_dv) begin
            state_q  <= StIdle;
            rx_abort <= 1'b1;
          end else if (!phase_q) begin
            lo_q    <= datain;
            phase_q <= 1'b1;
          end else begin
            phase_q  <= 1'b0;
            rx_valid <= 1'b1;
            rx_data  <= byte_w;
            rx_sof   <= first_q;
            first_q  <= 1'b0;
            remain_q <= remain_q - 16'd1;
            if (remain_q == 16'd1) begin
              rx_eof  <= 1'b1;
              pkt_cnt <= sat_inc(pkt_cnt);
              state_q <= StWait;
            end
          end
        end

        // Padding and FCS are skipped until the carrier drops.
        StWait, StDrop: begin
          if (!r_dv) begin
            state_q <= StIdle;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_rx_parser.sv
// Self-checking bench for udp_rx_parser: directed scenarios followed by randomized frames,
// each checked against a byte-offset reference model of the filter rules.
module tb_udp_rx_parser;

  localparam logic [47:0] LOCAL_MAC    = 48'h00_0A_35_01_FE_C0;
  localparam logic [31:0] LOCAL_IP     = 32'hC0_A8_00_02;
  localparam logic [15:0] PORT_BASE    = 16'd8080;
  localparam int unsigned NCH          = 4;
  localparam bit          ACCEPT_BCAST = 1'b1;
  localparam int unsigned CHW          = 2;
  localparam int          NONE         = 1 << 20;

  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    logic [7:0]     data;
    logic           sof;
    logic           eof;
    logic [CHW-1:0] ch;
    int             t;
  } strobe_t;

  logic           r_clk = 1'b0;
  logic           rst;
  logic           r_dv;
  logic [3:0]     datain;
  logic [7:0]     rx_data;
  logic           rx_valid;
  logic           rx_sof;
  logic           rx_eof;
  logic [CHW-1:0] rx_ch;
  logic           rx_abort;
  logic [47:0]    src_mac;
  logic [31:0]    src_ip;
  logic [15:0]    src_port;
  logic [15:0]    pkt_cnt;
  logic [15:0]    drop_cnt;

  always #5 r_clk = ~r_clk;

  udp_rx_parser #(
    .LOCAL_MAC    (LOCAL_MAC),
    .LOCAL_IP     (LOCAL_IP),
    .PORT_BASE    (PORT_BASE),
    .NCH          (NCH),
    .ACCEPT_BCAST (ACCEPT_BCAST)
  ) dut (
    .r_clk    (r_clk),
    .rst      (rst),
    .r_dv     (r_dv),
    .datain   (datain),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_sof   (rx_sof),
    .rx_eof   (rx_eof),
    .rx_ch    (rx_ch),
    .rx_abort (rx_abort),
    .src_mac  (src_mac),
    .src_ip   (src_ip),
    .src_port (src_port),
    .pkt_cnt  (pkt_cnt),
    .drop_cnt (drop_cnt)
  );

  int vectors = 0;
  int miscompares = 0;

  // Monitor: strobes and abort pulses sampled on the falling edge.
  int      cyc = 0;
  strobe_t cap[$];
  int      aborts = 0;
  always @(posedge r_clk) cyc <= cyc + 1;
  always @(negedge r_clk) begin
    if (rx_valid) cap.push_back('{data: rx_data, sof: rx_sof, eof: rx_eof, ch: rx_ch, t: cyc});
    if (rx_abort) aborts = aborts + 1;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Frame description, filled in by the stimulus steps.
  logic [47:0] f_dmac, f_smac;
  logic [15:0] f_etype, f_frag, f_sport, f_dport;
  logic [7:0]  f_vihl, f_proto;
  logic [31:0] f_sip, f_dip;
  int          f_ulen_ovr;
  int          f_pad;
  bit          f_badcs;
  byte_q_t     f_pay;
  byte_q_t     frm;

  logic [15:0] exp_pkt, exp_drop, exp_sport;
  logic [47:0] exp_smac;
  logic [31:0] exp_sip;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic dv, input logic [3:0] nib);
    r_dv   = dv;
    datain = nib;
    @(posedge r_clk);
    #1;
  endtask

  task automatic defaults();
    f_dmac     = LOCAL_MAC;
    f_smac     = {$urandom, $urandom} & 48'hFEFF_FFFF_FFFF;
    f_etype    = 16'h0800;
    f_vihl     = 8'h45;
    f_frag     = 16'h4000;
    f_proto    = 8'h11;
    f_sip      = $urandom;
    f_dip      = LOCAL_IP;
    f_sport    = 16'($urandom);
    f_dport    = PORT_BASE + 16'd1;
    f_ulen_ovr = -1;
    f_pad      = 0;
    f_badcs    = 1'b0;
    f_pay      = {};
  endtask

  task automatic push16(input logic [15:0] v);
    frm.push_back(v[15:8]);
    frm.push_back(v[7:0]);
  endtask

  task automatic build();
    logic [15:0] ip [10];
    logic [15:0] ulen;
    int unsigned s;
    frm = {};
    ulen = (f_ulen_ovr >= 0) ? 16'(f_ulen_ovr) : 16'(8 + f_pay.size());
    push16(f_dmac[47:32]); push16(f_dmac[31:16]); push16(f_dmac[15:0]);
    push16(f_smac[47:32]); push16(f_smac[31:16]); push16(f_smac[15:0]);
    push16(f_etype);
    ip[0] = {f_vihl, 8'h00};
    ip[1] = 16'd20 + ulen;
    ip[2] = 16'($urandom);
    ip[3] = f_frag;
    ip[4] = {8'd64, f_proto};
    ip[5] = 16'h0000;
    ip[6] = f_sip[31:16];
    ip[7] = f_sip[15:0];
    ip[8] = f_dip[31:16];
    ip[9] = f_dip[15:0];
    s = 0;
    for (int i = 0; i < 10; i++) s += ip[i];
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
    ip[5] = ~s[15:0];
    if (f_badcs) ip[5] = ip[5] ^ 16'h0100;
    for (int i = 0; i < 10; i++) push16(ip[i]);
    push16(f_sport); push16(f_dport); push16(ulen); push16(16'h0000);
    foreach (f_pay[i]) frm.push_back(f_pay[i]);
    for (int i = 0; i < f_pad + 4; i++) frm.push_back(8'($urandom));
  endtask

  task automatic send(input int nsent, input int ifg);
    for (int i = 0; i < 15; i++) drive(1'b1, 4'h5);
    drive(1'b1, 4'hD);
    for (int i = 0; i < nsent; i++) begin
      drive(1'b1, frm[i][3:0]);
      drive(1'b1, frm[i][7:4]);
    end
    for (int i = 0; i < ifg; i++) drive(1'b0, 4'h0);
  endtask

  // Reference: first failing rule by completing byte offset, then carrier-loss rules.
  task automatic model(input int nsent, output int n, output bit pkt, output bit drop,
                       output bit abort, output bit data);
    int          fail_at;
    int          len;
    logic [47:0] dm;
    logic [31:0] dip;
    logic [15:0] dport, ulen;
    fail_at = NONE;
    dm = '0;
    for (int i = 0; i < 6; i++) dm = {dm[39:0], frm[i]};
    dip   = {frm[30], frm[31], frm[32], frm[33]};
    dport = {frm[36], frm[37]};
    ulen  = {frm[38], frm[39]};
    if (dm != LOCAL_MAC && !(ACCEPT_BCAST && dm == 48'hFFFF_FFFF_FFFF)) fail_at = 5;
    if (fail_at == NONE && {frm[12], frm[13]} != 16'h0800) fail_at = 13;
    if (fail_at == NONE && frm[14] != 8'h45) fail_at = 14;
    if (fail_at == NONE && (frm[20][5] || {frm[20][4:0], frm[21]} != 13'd0)) fail_at = 21;
    if (fail_at == NONE && frm[23] != 8'h11) fail_at = 23;
    if (fail_at == NONE && dip != LOCAL_IP) fail_at = 33;
`ifdef UDP_RX_IPCSUM_EN
    begin
      int unsigned s;
      s = 0;
      for (int i = 14; i < 34; i += 2) s += {frm[i], frm[i+1]};
      while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
      if (fail_at == NONE && s != 32'hFFFF) fail_at = 33;
    end
`endif
    if (fail_at == NONE && (int'(dport) < int'(PORT_BASE) ||
                            int'(dport) >= int'(PORT_BASE) + int'(NCH))) fail_at = 37;
    if (fail_at == NONE && ulen < 16'd8) fail_at = 39;
    n = 0; pkt = 0; drop = 0; abort = 0; data = 0;
    len = int'(ulen) - 8;
    if (fail_at < nsent || nsent < 42) begin
      drop = 1;
    end else begin
      data = (len > 0);
      if (nsent >= 42 + len) begin
        n = len;
        pkt = 1;
      end else begin
        n = nsent - 42;
        abort = 1;
      end
    end
  endtask

  task automatic run_frame(input string tag, input int nsent, input int ifg);
    int cb, ab, n, got;
    bit pkt, drop, abort, data;
    logic [CHW-1:0] ch;
    cb = cap.size();
    ab = aborts;
    send(nsent, ifg);
    model(nsent, n, pkt, drop, abort, data);
    if (pkt && exp_pkt != 16'hFFFF) exp_pkt++;
    if (drop && exp_drop != 16'hFFFF) exp_drop++;
    if (data) begin
      exp_smac  = f_smac;
      exp_sip   = f_sip;
      exp_sport = f_sport;
    end
    ch = CHW'(f_dport - PORT_BASE);
    got = cap.size() - cb;
    chk({tag, "_nstrobes"}, 64'(got), 64'(n));
    for (int i = 0; i < got && i < n; i++) begin
      chk($sformatf("%s_data%0d", tag, i), 64'(cap[cb+i].data), 64'(frm[42+i]));
      chk($sformatf("%s_sof%0d", tag, i), 64'(cap[cb+i].sof), 64'(i == 0));
      chk($sformatf("%s_eof%0d", tag, i), 64'(cap[cb+i].eof), 64'(pkt && i == n - 1));
      chk($sformatf("%s_ch%0d", tag, i), 64'(cap[cb+i].ch), 64'(ch));
      if (i > 0) chk($sformatf("%s_gap%0d", tag, i), 64'(cap[cb+i].t - cap[cb+i-1].t), 64'd2);
    end
    chk({tag, "_abort"}, 64'(aborts - ab), 64'(abort));
    chk({tag, "_pkt_cnt"}, 64'(pkt_cnt), 64'(exp_pkt));
    chk({tag, "_drop_cnt"}, 64'(drop_cnt), 64'(exp_drop));
    chk({tag, "_src_mac"}, 64'(src_mac), 64'(exp_smac));
    chk({tag, "_src_ip"}, 64'(src_ip), 64'(exp_sip));
    chk({tag, "_src_port"}, 64'(src_port), 64'(exp_sport));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rx_valid"}, 64'(rx_valid), 64'd0);
    chk({tag, "_rx_sof"}, 64'(rx_sof), 64'd0);
    chk({tag, "_rx_eof"}, 64'(rx_eof), 64'd0);
    chk({tag, "_rx_abort"}, 64'(rx_abort), 64'd0);
    chk({tag, "_rx_data"}, 64'(rx_data), 64'd0);
    chk({tag, "_rx_ch"}, 64'(rx_ch), 64'd0);
    chk({tag, "_src_mac"}, 64'(src_mac), 64'd0);
    chk({tag, "_src_ip"}, 64'(src_ip), 64'd0);
    chk({tag, "_src_port"}, 64'(src_port), 64'd0);
    chk({tag, "_pkt_cnt"}, 64'(pkt_cnt), 64'd0);
    chk({tag, "_drop_cnt"}, 64'(drop_cnt), 64'd0);
  endtask

  initial begin
    int mode, nsent, cb, ab;
    rst = 1'b1; r_dv = 1'b0; datain = 4'h0;
    exp_pkt = '0; exp_drop = '0; exp_smac = '0; exp_sip = '0; exp_sport = '0;
    repeat (3) @(posedge r_clk);
    #1;
    rst = 1'b0;
    chk_zero("reset");
    drive(1'b0, 4'h0);

    // 1: port PORT_BASE+1, payload 01..05
    defaults();
    f_pay = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    build();
    run_frame("t1", frm.size(), 24);
    chk("t1_pkt_const", 64'(pkt_cnt), 64'd1);

    // 2: port just past the last channel
    defaults();
    f_pay = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    f_dport = PORT_BASE + 16'(NCH);
    build();
    run_frame("t2", frm.size(), 24);
    chk("t2_drop_const", 64'(drop_cnt), 64'd1);

    // 3: broadcast, two payload bytes then padding and FCS
    defaults();
    f_dmac = 48'hFFFF_FFFF_FFFF;
    f_dport = PORT_BASE + 16'(NCH - 1);
    f_pay = '{8'hAA, 8'hBB};
    f_pad = 16;
    build();
    run_frame("t3", frm.size(), 24);

    // 4: carrier lost after third of ten payload bytes
    defaults();
    for (int i = 0; i < 10; i++) f_pay.push_back(8'(8'h10 + i));
    build();
    run_frame("t4", 42 + 3, 24);

    // 5: corrupted IP header checksum
    defaults();
    f_pay = '{8'h5A, 8'hA5, 8'h3C};
    f_badcs = 1'b1;
    build();
    run_frame("t5", frm.size(), 24);

    // 6: reset mid-payload, then a clean frame after a 12-byte gap
    defaults();
    for (int i = 0; i < 10; i++) f_pay.push_back(8'($urandom));
    build();
    for (int i = 0; i < 15; i++) drive(1'b1, 4'h5);
    drive(1'b1, 4'hD);
    for (int i = 0; i < 46; i++) begin
      drive(1'b1, frm[i][3:0]);
      drive(1'b1, frm[i][7:4]);
    end
    ab = aborts;
    rst = 1'b1;
    drive(1'b0, 4'h0);
    rst = 1'b0;
    cb = cap.size();
    chk_zero("t6_rst");
    exp_pkt = '0; exp_drop = '0; exp_smac = '0; exp_sip = '0; exp_sport = '0;
    for (int i = 0; i < 24; i++) drive(1'b0, 4'h0);
    chk("t6_no_abort", 64'(aborts - ab), 64'd0);
    chk("t6_no_strobe", 64'(cap.size() - cb), 64'd0);
    defaults();
    f_dport = PORT_BASE + 16'd2;
    f_pay = '{8'hC1, 8'hC2, 8'hC3};
    build();
    run_frame("t6", frm.size(), 24);
    chk("t6_pkt_const", 64'(pkt_cnt), 64'd1);

    // Randomized frames
    for (int k = 0; k < 40; k++) begin
      defaults();
      f_dport = PORT_BASE + 16'($urandom_range(0, NCH - 1));
      if ($urandom_range(0, 3) == 0) f_dmac = 48'hFFFF_FFFF_FFFF;
      for (int i = 0, n = $urandom_range(0, 12); i < n; i++) f_pay.push_back(8'($urandom));
      f_pad = $urandom_range(0, 20);
      f_badcs = ($urandom_range(0, 7) == 0);
      mode = $urandom_range(0, 12);
      case (mode)
        5:  f_dmac = {8'h02, 8'($urandom), 32'($urandom)};
        6:  f_etype = 16'h86DD;
        7:  f_vihl = 8'h46;
        8:  f_frag = ($urandom_range(0, 1) == 1) ? 16'h2000 : 16'(16'h0001 + $urandom_range(0, 99));
        9:  f_proto = 8'h06;
        10: f_dip = LOCAL_IP ^ (32'd1 << $urandom_range(0, 31));
        11: f_dport = ($urandom_range(0, 1) == 1) ? 16'(PORT_BASE - 16'd1 - 16'($urandom_range(0, 5)))
                                                  : 16'(PORT_BASE + 16'(NCH) + 16'($urandom_range(0, 50)));
        12: f_ulen_ovr = $urandom_range(0, 7);
        default: ;
      endcase
      build();
      nsent = ($urandom_range(0, 3) == 0) ? $urandom_range(1, frm.size()) : frm.size();
      run_frame($sformatf("r%0d", k), nsent, $urandom_range(4, 24));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
